// File: rtl/i2c_slave_burst.sv
// I2C target with burst read/write, auto-incrementing register pointer and repeated START.
// Define I2C_SLV_STRETCH_EN to hold SCL low until i_rd_valid instead of using a fixed RD_LAT.
module i2c_slave_burst #(
  parameter int REG_AW      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire               scl,
  inout  wire               sda,
  input  logic [6:0]        i_slave_addr,
  input  logic [7:0]        i_rd_data,
  input  logic              i_rd_valid,
  output logic              o_wr_en,
  output logic [REG_AW-1:0] o_reg_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_rd_req,
  output logic              o_busy,
  output logic              sda_oe
);

  localparam int OFFB = (REG_AW + 7) / 8;
  localparam int OFFW = OFFB * 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFFS, OFFS_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t                  state_r;
  logic [SYNC_STAGES-1:0]  scl_sync_r, sda_sync_r;
  logic                    scl_prev_r, sda_prev_r;
  logic                    scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [3:0]              bit_cnt_r;
  logic [1:0]              off_cnt_r;
  logic [7:0]              rx_r, tx_r, tx_next_s;
  logic [OFFW-1:0]         off_sh_r;
  logic                    rw_r, rd_fire_s, scl_oe_r;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign tx_next_s  = rd_fire_s ? i_rd_data : tx_r;

  assign sda = sda_oe   ? 1'b0 : 1'bz;
  assign scl = scl_oe_r ? 1'b0 : 1'bz;

  // Pad synchronisers and edge history; idle bus reads as 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

`ifdef I2C_SLV_STRETCH_EN
  logic rd_pend_r;
  logic unused_s;

  assign unused_s  = ^{RD_LAT};
  assign rd_fire_s = rd_pend_r & i_rd_valid;

  // Hold SCL low from the first fall after a read request until the source answers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r <= 1'b0;
      scl_oe_r  <= 1'b0;
    end else if (start_s || stop_s) begin
      rd_pend_r <= 1'b0;
      scl_oe_r  <= 1'b0;
    end else begin
      if (o_rd_req)       rd_pend_r <= 1'b1;
      else if (rd_fire_s) rd_pend_r <= 1'b0;
      if (rd_fire_s)                    scl_oe_r <= 1'b0;
      else if (scl_fall_s && rd_pend_r) scl_oe_r <= 1'b1;
    end
  end
`else
  logic [RD_LAT-1:0] rd_pipe_r;
  logic              unused_s;

  assign unused_s  = i_rd_valid;
  assign rd_fire_s = rd_pipe_r[RD_LAT-1];
  assign scl_oe_r  = 1'b0;

  // Fixed-latency read return: latch data RD_LAT cycles after the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe_r <= '0;
    else        rd_pipe_r <= (rd_pipe_r << 1) | RD_LAT'(o_rd_req);
  end
`endif

  // Protocol FSM; SDA is updated one clk after the synchronised SCL fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      off_cnt_r  <= 2'd0;
      rx_r       <= 8'h00;
      tx_r       <= 8'h00;
      off_sh_r   <= '0;
      rw_r       <= 1'b0;
      o_wr_en    <= 1'b0;
      o_reg_addr <= '0;
      o_wr_data  <= 8'h00;
      o_rd_req   <= 1'b0;
      o_busy     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      o_wr_en  <= 1'b0;
      o_rd_req <= 1'b0;
      tx_r     <= tx_next_s;
      if (start_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe    <= 1'b0;
      end else if (stop_s) begin
        state_r <= IDLE;
        sda_oe  <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        case (state_r)
          ADDR: begin
            if (scl_rise_s) begin
              rx_r      <= {rx_r[6:0], sda_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              rw_r      <= rx_r[0];
              bit_cnt_r <= 4'd0;
              if (rx_r[7:1] == i_slave_addr) begin
                state_r <= ADDR_ACK;
                sda_oe  <= 1'b1;
                o_busy  <= 1'b1;
              end else begin
                state_r <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_rise_s && rw_r) begin
              o_rd_req <= 1'b1;
            end else if (scl_fall_s) begin
              if (rw_r) begin
                state_r <= RDATA;
                sda_oe  <= ~tx_next_s[7];
              end else begin
                state_r   <= OFFS;
                sda_oe    <= 1'b0;
                off_cnt_r <= 2'd0;
              end
            end
          end
          OFFS, WDATA: begin
            if (scl_rise_s) begin
              rx_r      <= {rx_r[6:0], sda_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (state_r == OFFS) begin
                off_sh_r <= {off_sh_r[OFFW-2:0], sda_s};
              end else if (bit_cnt_r == 4'd7) begin
                o_wr_en   <= 1'b1;
                o_wr_data <= {rx_r[6:0], sda_s};
              end
            end else if (scl_fall_s && bit_cnt_r == 4'd8) begin
              state_r   <= (state_r == OFFS) ? OFFS_ACK : WDATA_ACK;
              sda_oe    <= 1'b1;
              bit_cnt_r <= 4'd0;
            end
          end
          OFFS_ACK: begin
            if (scl_fall_s) begin
              sda_oe <= 1'b0;
              if (off_cnt_r == 2'(OFFB - 1)) begin
                state_r    <= WDATA;
                o_reg_addr <= off_sh_r[REG_AW-1:0];
              end else begin
                state_r   <= OFFS;
                off_cnt_r <= off_cnt_r + 2'd1;
              end
            end
          end
          WDATA_ACK: begin
            if (scl_fall_s) begin
              sda_oe     <= 1'b0;
              o_reg_addr <= o_reg_addr + REG_AW'(1);
              state_r    <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                state_r   <= RDATA_ACK;
                sda_oe    <= 1'b0;
                bit_cnt_r <= 4'd0;
              end else begin
                tx_r   <= {tx_next_s[6:0], 1'b0};
                sda_oe <= ~tx_next_s[6];
              end
            end else if (rd_fire_s && bit_cnt_r == 4'd0) begin
              // Stretched read: first bit goes out once the data arrives
              sda_oe <= ~i_rd_data[7];
            end
          end
          RDATA_ACK: begin
            if (scl_rise_s) begin
              o_reg_addr <= o_reg_addr + REG_AW'(1);
              if (sda_s) state_r  <= IGNORE;
              else       o_rd_req <= 1'b1;
            end else if (scl_fall_s) begin
              state_r <= RDATA;
              sda_oe  <= ~tx_next_s[7];
            end
          end
          IDLE, IGNORE: sda_oe <= 1'b0;
          default:      state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_burst.sv
// Scoreboard bench for i2c_slave_burst: bit-banged open-drain master, register-file responder.
module tb_i2c_slave_burst;
  localparam int Q = 6;
`ifdef I2C_SLV_STRETCH_EN
  localparam int RSP_DLY = 50;
`else
  localparam int RSP_DLY = 2;
`endif

  typedef struct {
    bit         is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  wire        scl_w, sda_w;
  logic       m_scl_low, m_sda_low;
  logic [7:0] i_rd_data;
  logic       i_rd_valid;
  logic       o_wr_en, o_rd_req, o_busy, sda_oe;
  logic [7:0] o_reg_addr, o_wr_data;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  stretch_cyc = 0;
  int  sda_drv_cnt = 0;
  int  rsp_cnt = 0;
  logic [7:0] rsp_val;
  ev_t exp_q[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  assign scl_w = m_scl_low ? 1'b0 : 1'bz;
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl_w);
  pullup (sda_w);

  i2c_slave_burst dut (
    .clk(clk), .rst_n(rst_n), .scl(scl_w), .sda(sda_w),
    .i_slave_addr(7'h05), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
    .o_wr_en(o_wr_en), .o_reg_addr(o_reg_addr), .o_wr_data(o_wr_data),
    .o_rd_req(o_rd_req), .o_busy(o_busy), .sda_oe(sda_oe)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops the next expected event
  always @(negedge clk) begin
    if (sda_oe) sda_drv_cnt++;
    if (o_wr_en || o_rd_req) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", int'(o_reg_addr), -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind", int'(o_wr_en), int'(mon_e.is_wr));
        chk("strobe_addr", int'(o_reg_addr), int'(mon_e.addr));
        if (o_wr_en) chk("wr_data", int'(o_wr_data), int'(mon_e.data));
      end
    end
  end

  // Register-file responder: garbage until the data is due, mem[a] = a ^ A5
  always @(negedge clk) begin
    i_rd_valid = 1'b0;
    if (o_rd_req) begin
      rsp_val   = o_reg_addr ^ 8'hA5;
      i_rd_data = ~rsp_val;
      rsp_cnt   = RSP_DLY;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        i_rd_data  = rsp_val;
        i_rd_valid = 1'b1;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic scl_release();
    int w = 0;
    m_scl_low = 1'b0;
    @(posedge clk);
    while (scl_w !== 1'b1 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    if (w > stretch_cyc) stretch_cyc = w;
    if (w >= 2000) chk("scl_release_timeout", w, 0);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b;
    wait_clk(Q);
    scl_release();
    wait_clk(2 * Q);
    m_scl_low = 1'b1;
    wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    b = sda_w;
    wait_clk(Q);
    m_scl_low = 1'b1;
    wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  task automatic start_c();
    m_sda_low = 1'b0;
    wait_clk(Q);
    if (m_scl_low) scl_release();
    wait_clk(Q);
    m_sda_low = 1'b1;
    wait_clk(Q);
    m_scl_low = 1'b1;
    wait_clk(Q);
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1;
    wait_clk(Q);
    scl_release();
    wait_clk(Q);
    m_sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic push(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = is_wr;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic wr_ack(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    send_byte(d, a);
    chk(name, int'(a), int'(exp_ack));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    i_rd_data = 8'h00;
    i_rd_valid = 1'b0;
    wait_clk(5);
    @(negedge clk);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_wr_en", int'(o_wr_en), 0);
    chk("rst_rd_req", int'(o_rd_req), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_reg_addr", int'(o_reg_addr), 0);
    chk("rst_scl_released", int'(scl_w), 1);
    chk("rst_sda_released", int'(sda_w), 1);
    rst_n = 1'b1;
    wait_clk(10);

    // Burst write 0x10: AA, BB
    push(1'b1, 8'h10, 8'hAA);
    push(1'b1, 8'h11, 8'hBB);
    start_c();
    wr_ack("t2_ack_addr", 8'h0A, 1'b0);
    wr_ack("t2_ack_offs", 8'h10, 1'b0);
    wr_ack("t2_ack_d0", 8'hAA, 1'b0);
    wr_ack("t2_ack_d1", 8'hBB, 1'b0);
    chk("t2_busy_before_stop", int'(o_busy), 1);
    stop_c();
    chk("t2_busy_after_stop", int'(o_busy), 0);

    // Offset 0x20, repeated START, read ACK/ACK/NACK
    push(1'b0, 8'h20, 8'h00);
    push(1'b0, 8'h21, 8'h00);
    push(1'b0, 8'h22, 8'h00);
    start_c();
    wr_ack("t3_ack_addr", 8'h0A, 1'b0);
    wr_ack("t3_ack_offs", 8'h20, 1'b0);
    start_c();
    wr_ack("t3_ack_raddr", 8'h0B, 1'b0);
    recv_byte(d, 1'b0);
    chk("t3_rd0", int'(d), 8'h85);
    recv_byte(d, 1'b0);
    chk("t3_rd1", int'(d), 8'h84);
    recv_byte(d, 1'b1);
    chk("t3_rd2", int'(d), 8'h87);
    chk("t3_reg_addr", int'(o_reg_addr), 8'h23);
    stop_c();

    // Foreign address 0x06 is ignored, then re-decode after START
    sda_drv_cnt = 0;
    start_c();
    wr_ack("t4_nack_addr", 8'h0C, 1'b1);
    chk("t4_busy", int'(o_busy), 0);
    wr_ack("t4_nack_data", 8'h33, 1'b1);
    chk("t4_sda_driven", sda_drv_cnt, 0);
    start_c();
    wr_ack("t4_ack_redecode", 8'h0A, 1'b0);
    wr_ack("t4_ack_offs", 8'h40, 1'b0);
    stop_c();
    chk("t4_reg_addr", int'(o_reg_addr), 8'h40);

    // Pointer wrap 0xFF -> 0x00
    push(1'b1, 8'hFF, 8'h11);
    push(1'b1, 8'h00, 8'h22);
    push(1'b1, 8'h01, 8'h33);
    start_c();
    wr_ack("t5_ack_addr", 8'h0A, 1'b0);
    wr_ack("t5_ack_offs", 8'hFF, 1'b0);
    wr_ack("t5_ack_d0", 8'h11, 1'b0);
    wr_ack("t5_ack_d1", 8'h22, 1'b0);
    wr_ack("t5_ack_d2", 8'h33, 1'b0);
    stop_c();
    chk("t5_reg_addr", int'(o_reg_addr), 8'h02);

    // Single read at 0x02; stretch only in the stretch build
    stretch_cyc = 0;
    push(1'b0, 8'h02, 8'h00);
    start_c();
    wr_ack("t6_ack_raddr", 8'h0B, 1'b0);
    recv_byte(d, 1'b1);
    chk("t6_rd", int'(d), 8'hA7);
    stop_c();
`ifdef I2C_SLV_STRETCH_EN
    chk("t6_stretched", int'(stretch_cyc > 20), 1);
`else
    chk("t6_no_stretch", stretch_cyc, 0);
`endif

    wait_clk(10);
    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
